fetch_stage: RTL

- IF-stage front end of the 5-stage RV32I pipeline.
- Owns the program counter and drives the word address into the combinational instruction ROM.
- Captures the returned instruction into the IF/ID pipeline register for decode.
- Handles decode stalls, branch redirects and flushes, and halts on an unpopulated ROM word (all-zero instruction).

---
 rtl/fetch_stage.sv | 123 ++++++++++++
 1 files changed

// File: rtl/fetch_stage.sv
// IF stage of the 5-stage RV32I pipeline: PC register, ROM addressing and IF/ID register.
// Optional fetch/stall performance counters are built when FETCH_PERF_CNT_EN is defined.
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_instr,
  input  logic        stall,
  input  logic        flush,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic [31:0] if_id_pc,
  output logic [31:0] if_id_pc_plus4,
  output logic [31:0] if_id_instr,
  output logic        if_id_valid,
  output logic        halted
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] fetch_count,
  output logic [31:0] stall_count
`endif
);

  typedef enum logic {RUN = 1'b0, HALT = 1'b1} state_t;

  state_t      state;
  state_t      state_next;
  logic [31:0] pc;
  logic [31:0] pc_next;
  logic [31:0] pc_plus4;
  logic [31:0] redirect_pc;
  logic        bubble;
  logic        capture;
  logic        unused_target_bits;

  assign pc_plus4           = pc + 32'd4;
  assign redirect_pc        = {branch_target[31:2], 2'b00};
  assign unused_target_bits = ^branch_target[1:0];
  assign imem_addr          = pc;
  assign halted             = (state == HALT);

  // IF/ID either loads a bubble, captures the fetched word, or holds (neither set).
  always_comb begin
    state_next = state;
    pc_next    = pc;
    bubble     = 1'b0;
    capture    = 1'b0;
    unique case (state)
      RUN: begin
        if (branch_taken) begin
          pc_next = redirect_pc;
          bubble  = 1'b1;
        end else if (flush) begin
          bubble = 1'b1;
          if (!stall) pc_next = pc_plus4;
        end else if (!stall) begin
          if (imem_instr == 32'h0) begin
            state_next = HALT;
            bubble     = 1'b1;
          end else begin
            pc_next = pc_plus4;
            capture = 1'b1;
          end
        end
      end
      HALT: begin
        if (branch_taken) begin
          state_next = RUN;
          pc_next    = redirect_pc;
          bubble     = 1'b1;
        end else if (flush || !stall) begin
          bubble = 1'b1;
        end
      end
      default: begin
        state_next = RUN;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= RUN;
      pc    <= RESET_PC;
    end else begin
      state <= state_next;
      pc    <= pc_next;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      if_id_pc       <= 32'h0000_0000;
      if_id_pc_plus4 <= 32'h0000_0004;
      if_id_instr    <= NOP_INSTR;
      if_id_valid    <= 1'b0;
    end else if (bubble) begin
      if_id_instr <= NOP_INSTR;
      if_id_valid <= 1'b0;
    end else if (capture) begin
      if_id_pc       <= pc;
      if_id_pc_plus4 <= pc_plus4;
      if_id_instr    <= imem_instr;
      if_id_valid    <= 1'b1;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_count <= 32'h0;
      stall_count <= 32'h0;
    end else begin
      if (capture) fetch_count <= fetch_count + 32'd1;
      if (stall && state == RUN) stall_count <= stall_count + 32'd1;
    end
  end
`endif

endmodule
